// File: rtl/rr_mux_n.sv
// rr_mux_n: round-robin N:1 valid/ready arbiter with a registered output stage.
// Each beat is arbitrated independently, or with PACKET=1 the grant stays on one
// channel from its first beat until the beat that carries in_last.
module rr_mux_n #(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = 32,
  parameter int unsigned PACKET = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*W-1:0]         in_data,
  input  logic [N-1:0]           in_valid,
  input  logic [N-1:0]           in_last,
  output logic [N-1:0]           in_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_sel,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned SW = $clog2(N);

  // Packet lock state: open means any channel may win the next beat.
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_e;

  lock_e          lock_q, lock_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [SW-1:0]  lk_ch_q, lk_ch_d;

  logic [W-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]  out_sel_q, out_sel_d;
  logic           out_last_q, out_last_d;
  logic           out_valid_q, out_valid_d;

  logic [N-1:0]   elig;
  logic           gnt_vld;
  logic [SW-1:0]  gnt_idx;
  int unsigned    scan_idx;
  logic [W-1:0]   sel_data;
  logic           sel_last;
  logic           load;

  // Elaboration-time parameter sanity check.
  if (N < 2) begin : g_bad_n
    $error("rr_mux_n: N must be at least 2");
  end

  // Eligible channels: everyone when open, only the locked channel mid-packet.
  always_comb begin
    elig = in_valid;
    if (PACKET != 0) begin
      case (lock_q)
        ST_LOCKED: begin
          elig          = '0;
          elig[lk_ch_q] = in_valid[lk_ch_q];
        end
        default: elig = in_valid;
      endcase
    end
  end

  // Round-robin scan starting at ptr; descending loop so the nearest index wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      scan_idx = 32'(ptr_q) + 32'(k);
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      if (elig[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(scan_idx);
      end
    end
  end

  // Payload mux for the granted channel.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_idx == SW'(i)) begin
        sel_data = in_data[i*W +: W];
        sel_last = in_last[i];
      end
    end
  end

  // Output stage accepts a beat when empty or being drained this cycle.
  assign load = rst & (~out_valid_q | out_ready) & gnt_vld;

  // Ready goes only to the winner, and only when the beat is actually taken.
  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state: output register, pointer and packet lock.
  always_comb begin
    lock_d      = lock_q;
    lk_ch_d     = lk_ch_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = gnt_idx;
      out_last_d  = (PACKET != 0) ? sel_last : 1'b1;
      if ((PACKET == 0) || sel_last) begin
        // Explicit wrap keeps non-power-of-2 N correct.
        ptr_d  = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
        lock_d = ST_OPEN;
      end else begin
        lock_d  = ST_LOCKED;
        lk_ch_d = gnt_idx;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q      <= ST_OPEN;
      lk_ch_q     <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lk_ch_q     <= lk_ch_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  // At most one channel may see ready in any cycle.
  a_rdy_onehot: assert property (@(posedge clk) $onehot0(in_ready))
    else $error("rr_mux_n: in_ready not one-hot or zero");

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: three instances (N=4 beat mode, N=3 beat mode, N=4 packet mode)
// driven from one table of directed vectors plus a hand-written stall sequence.
module tb_rr_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, W=8, PACKET=0
  logic        rst_a = 1'b0;
  logic [31:0] data_a = '0;
  logic [3:0]  valid_a = '0, last_a = '0, rdy_a;
  logic [7:0]  odata_a;
  logic [1:0]  osel_a;
  logic        olast_a, ovld_a, ordy_a = 1'b0;

  // Instance B: N=3, W=8, PACKET=0
  logic        rst_b = 1'b0;
  logic [23:0] data_b = '0;
  logic [2:0]  valid_b = '0, last_b = '0, rdy_b;
  logic [7:0]  odata_b;
  logic [1:0]  osel_b;
  logic        olast_b, ovld_b, ordy_b = 1'b0;

  // Instance C: N=4, W=8, PACKET=1
  logic        rst_c = 1'b0;
  logic [31:0] data_c = '0;
  logic [3:0]  valid_c = '0, last_c = '0, rdy_c;
  logic [7:0]  odata_c;
  logic [1:0]  osel_c;
  logic        olast_c, ovld_c, ordy_c = 1'b0;

  rr_mux_n #(.N(4), .W(8), .PACKET(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .in_data(data_a), .in_valid(valid_a), .in_last(last_a),
    .in_ready(rdy_a), .out_data(odata_a), .out_sel(osel_a), .out_last(olast_a),
    .out_valid(ovld_a), .out_ready(ordy_a));

  rr_mux_n #(.N(3), .W(8), .PACKET(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_data(data_b), .in_valid(valid_b), .in_last(last_b),
    .in_ready(rdy_b), .out_data(odata_b), .out_sel(osel_b), .out_last(olast_b),
    .out_valid(ovld_b), .out_ready(ordy_b));

  rr_mux_n #(.N(4), .W(8), .PACKET(1)) u_dut_c (
    .clk(clk), .rst(rst_c), .in_data(data_c), .in_valid(valid_c), .in_last(last_c),
    .in_ready(rdy_c), .out_data(odata_c), .out_sel(osel_c), .out_last(olast_c),
    .out_valid(ovld_c), .out_ready(ordy_c));

  typedef struct {
    logic [1:0]  dut;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        out_ready;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic        chk;
    logic [7:0]  exp_data;
    logic [1:0]  exp_sel;
    logic        exp_last;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [1:0] d, input logic r, input logic [3:0] vl,
                              input logic [3:0] ls, input logic [31:0] dt, input logic ordy,
                              input logic [3:0] erdy, input logic evld, input logic ck,
                              input logic [7:0] ed, input logic [1:0] es, input logic el);
    vec_t v;
    v.dut = d; v.rst = r; v.valid = vl; v.last = ls; v.data = dt; v.out_ready = ordy;
    v.exp_rdy = erdy; v.exp_vld = evld; v.chk = ck; v.exp_data = ed; v.exp_sel = es;
    v.exp_last = el;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  localparam logic [31:0] DA = 32'hA3A2A1A0;
  localparam logic [31:0] DB = 32'h00B2B1B0;

  initial begin
    vec_t        v;
    logic [3:0]  act_rdy;
    logic [7:0]  act_data;
    logic [1:0]  act_sel;
    logic        act_last, act_vld;
    bit          seen;

    // A: reset, fairness, backpressure with refill, wrap 3 -> 0
    vecs.push_back(mk(0, 0, 4'hF, 4'h0, DA, 1, 4'h0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 4'hF, 4'h0, DA, 1, 4'h0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, DA, 1, 4'h1, 1, 1, 8'hA0, 0, 1));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, DA, 1, 4'h2, 1, 1, 8'hA1, 1, 1));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, DA, 1, 4'h4, 1, 1, 8'hA2, 2, 1));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, DA, 1, 4'h8, 1, 1, 8'hA3, 3, 1));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, DA, 1, 4'h1, 1, 1, 8'hA0, 0, 1));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, DA, 1, 4'h2, 1, 1, 8'hA1, 1, 1));
    vecs.push_back(mk(0, 1, 4'h4, 4'h0, 32'h005C0000, 1, 4'h4, 1, 1, 8'h5C, 2, 1));
    vecs.push_back(mk(0, 1, 4'h4, 4'h0, 32'h005D0000, 0, 4'h0, 1, 1, 8'h5C, 2, 1));
    vecs.push_back(mk(0, 1, 4'h4, 4'h0, 32'h005D0000, 0, 4'h0, 1, 1, 8'h5C, 2, 1));
    vecs.push_back(mk(0, 1, 4'h4, 4'h0, 32'h005D0000, 0, 4'h0, 1, 1, 8'h5C, 2, 1));
    vecs.push_back(mk(0, 1, 4'h4, 4'h0, 32'h005D0000, 1, 4'h4, 1, 1, 8'h5D, 2, 1));
    vecs.push_back(mk(0, 1, 4'h0, 4'h0, DA, 1, 4'h0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4'h0, DA, 0, 4'h0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 4'hB, 4'h0, DA, 1, 4'h8, 1, 1, 8'hA3, 3, 1));
    vecs.push_back(mk(0, 1, 4'hB, 4'h0, DA, 1, 4'h1, 1, 1, 8'hA0, 0, 1));
    // B: N=3 wrap from ptr=2
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, DB, 1, 4'h0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 4'h2, 4'h0, DB, 1, 4'h2, 1, 1, 8'hB1, 1, 1));
    vecs.push_back(mk(1, 1, 4'h5, 4'h0, DB, 1, 4'h4, 1, 1, 8'hB2, 2, 1));
    vecs.push_back(mk(1, 1, 4'h5, 4'h0, DB, 1, 4'h1, 1, 1, 8'hB0, 0, 1));
    vecs.push_back(mk(1, 1, 4'h7, 4'h0, DB, 1, 4'h2, 1, 1, 8'hB1, 1, 1));
    vecs.push_back(mk(1, 1, 4'h7, 4'h0, DB, 1, 4'h4, 1, 1, 8'hB2, 2, 1));
    vecs.push_back(mk(1, 1, 4'h7, 4'h0, DB, 1, 4'h1, 1, 1, 8'hB0, 0, 1));
    // C: packet lock with valid gap, then reset mid-packet
    vecs.push_back(mk(2, 0, 4'hB, 4'h9, 32'hC30011C0, 1, 4'h0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30011C0, 1, 4'h1, 1, 1, 8'hC0, 0, 1));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30011C0, 1, 4'h2, 1, 1, 8'h11, 1, 0));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30012C0, 1, 4'h2, 1, 1, 8'h12, 1, 0));
    vecs.push_back(mk(2, 1, 4'h9, 4'h9, 32'hC30012C0, 1, 4'h0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(2, 1, 4'hB, 4'hB, 32'hC30013C0, 1, 4'h2, 1, 1, 8'h13, 1, 1));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30014C0, 1, 4'h8, 1, 1, 8'hC3, 3, 1));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30014C0, 1, 4'h1, 1, 1, 8'hC0, 0, 1));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30021C0, 1, 4'h2, 1, 1, 8'h21, 1, 0));
    vecs.push_back(mk(2, 0, 4'hB, 4'h9, 32'hC30022C0, 1, 4'h0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30022C0, 1, 4'h1, 1, 1, 8'hC0, 0, 1));
    vecs.push_back(mk(2, 1, 4'hB, 4'h9, 32'hC30022C0, 1, 4'h2, 1, 1, 8'h22, 1, 0));
    vecs.push_back(mk(2, 1, 4'hB, 4'hB, 32'hC30023C0, 1, 4'h2, 1, 1, 8'h23, 1, 1));

    @(negedge clk);
    foreach (vecs[i]) begin
      v = vecs[i];
      case (v.dut)
        2'd0: begin
          rst_a = v.rst; valid_a = v.valid; last_a = v.last; data_a = v.data;
          ordy_a = v.out_ready;
        end
        2'd1: begin
          rst_b = v.rst; valid_b = v.valid[2:0]; last_b = v.last[2:0];
          data_b = v.data[23:0]; ordy_b = v.out_ready;
        end
        default: begin
          rst_c = v.rst; valid_c = v.valid; last_c = v.last; data_c = v.data;
          ordy_c = v.out_ready;
        end
      endcase
      #1;
      case (v.dut)
        2'd0:    act_rdy = rdy_a;
        2'd1:    act_rdy = {1'b0, rdy_b};
        default: act_rdy = rdy_c;
      endcase
      check("in_ready", i, 32'(act_rdy), 32'(v.exp_rdy));
      @(posedge clk);
      #1;
      case (v.dut)
        2'd0:    begin act_vld = ovld_a; act_data = odata_a; act_sel = osel_a; act_last = olast_a; end
        2'd1:    begin act_vld = ovld_b; act_data = odata_b; act_sel = osel_b; act_last = olast_b; end
        default: begin act_vld = ovld_c; act_data = odata_c; act_sel = osel_c; act_last = olast_c; end
      endcase
      check("out_valid", i, 32'(act_vld), 32'(v.exp_vld));
      if (v.chk) begin
        check("out_data", i, 32'(act_data), 32'(v.exp_data));
        check("out_sel", i, 32'(act_sel), 32'(v.exp_sel));
        check("out_last", i, 32'(act_last), 32'(v.exp_last));
      end
      @(negedge clk);
    end

    // Packet-mode stall: capture a single-beat ch2 packet, then hold it under backpressure.
    valid_c = 4'h4; last_c = 4'h4; data_c = 32'h00770000; ordy_c = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (ovld_c && odata_c == 8'h77) seen = 1'b1;
    end
    check("stall_capture", 100, 32'(seen), 32'd1);
    @(negedge clk);
    ordy_c = 1'b0; data_c = 32'h00880000;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_rdy", 101 + c, 32'(rdy_c), 32'd0);
      @(posedge clk);
      #1;
      check("stall_vld", 101 + c, 32'(ovld_c), 32'd1);
      check("stall_data", 101 + c, 32'(odata_c), 32'h77);
      check("stall_sel", 101 + c, 32'(osel_c), 32'd2);
      @(negedge clk);
    end
    ordy_c = 1'b1;
    #1;
    check("refill_rdy", 104, 32'(rdy_c), 32'h4);
    @(posedge clk);
    #1;
    check("refill_data", 104, 32'(odata_c), 32'h88);
    check("refill_vld", 104, 32'(ovld_c), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- Sequential, parametrised successor to the combinational N:1 mux tree.
- Selects one of N valid/ready input channels by round-robin arbitration and registers the winner into a single output stage.
- Optional packet mode holds the grant until the end of a multi-beat packet.
- Sits between multiple producers (e.g. per-unit result buses) and one shared consumer.

Parameters:
- N, 4, number of input channels; N >= 2, need not be a power of 2.
- W, 32, data width per channel.
- PACKET, 0, 1 = grant is locked from the first beat until the in_last beat; 0 = every beat is arbitrated independently.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-low reset.
- in_data  input  N*W  channel i data at bits [i*W +: W]; channel 0 occupies [W-1:0].
- in_valid  input  N  per-channel valid.
- in_last  input  N  per-channel end-of-packet flag; ignored when PACKET=0.
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_data  output  W  registered data of the granted beat.
- out_sel  output  $clog2(N)  index of the channel that produced out_data.
- out_last  output  1  registered in_last of the granted beat; forced to 1 when PACKET=0.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst=0 at a clk edge): out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, lock=0, lk_ch=0. in_ready is combinational and is 0 during reset.
- Output register:
  - load = rst & (~out_valid | out_ready) & (some channel is eligible and valid).
  - On load: out_data, out_sel, out_last and out_valid=1 are captured.
  - If out_valid & out_ready & ~load, out_valid is cleared to 0.
  - Latency is 1 cycle from an input handshake to out_valid.
  - Throughput is 1 beat per cycle when out_ready is held at 1.
- Handshake:
  - in_ready[g] = load & (grant==g); all other bits are 0.
  - A transfer occurs on in_valid[g] & in_ready[g].
  - out_data is held stable while out_valid & ~out_ready.
- Arbitration (combinational grant):
  - Unlocked: grant = first i with in_valid[i], scanning ptr, ptr+1, ... wrapping mod N.
  - Locked (PACKET=1, lock=1): only lk_ch is eligible. Other channels stall even while lk_ch is idle.
- Pointer and lock update, on a transfer from channel g only:
  - PACKET=0, or in_last[g]=1: ptr <= (g+1) mod N and lock <= 0. Wrap is explicit for non-power-of-2 N (g=N-1 -> 0).
  - PACKET=1 and in_last[g]=0: lock <= 1, lk_ch <= g, and ptr is unchanged.
- No transfer: ptr, lock and lk_ch hold.
- Simultaneous free and refill (out_valid & out_ready & new load): the new beat replaces the old one with no bubble, and out_valid stays 1.
- Mid-operation reset: drops any held beat and any lock. No partial packet is completed afterwards.
- No data combinational path from inputs to outputs. The only combinational input-to-output path is in_valid/out_ready -> in_ready.
- Simulation-time checks:
  - $error if N < 2.
  - Assertion that in_ready is one-hot or zero.

Test Plan:
- Reset: N=4, W=8; hold rst=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Fairness: all four in_valid=1 with data 8'hA0..8'hA3, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with out_data matching and no idle cycles.
- Backpressure: only ch2 valid (8'h5C), out_ready=0 for 3 cycles -> out_valid=1, out_data=8'h5C held stable, in_ready=0000 after capture; raise out_ready -> the next beat loads the same cycle, no bubble.
- Wrap with N=3 (non-power-of-2): ch2 and ch0 valid, ptr=2 -> grants ch2 then ch0; ptr returns to 1 after the ch0 transfer.
- Packet lock: PACKET=1; ch1 sends 3 beats with in_last=0,0,1 while ch0 and ch3 are valid throughout; insert a 1-cycle ch1 valid gap -> out_sel=1 for all 3 beats, no grant during the gap, then ch3 is granted next.
- Reset mid-packet: PACKET=1, ch1 locked after beat 1; assert rst=0 for 1 cycle -> lock cleared, ptr=0; ch0 is granted first after release.
